// File: rtl/pixel_format_frame_writer_if.sv
// Pixel stream in (valid/ready) and frame-buffer write stream out (we/wr_ready).
// The slave modport is the packer's view; the master modport is the producer/consumer side.
interface pixel_format_frame_writer_if #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [23:0]           data_rgb888;
    logic                  valid;
    logic                  ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  wr_ready;

    modport master (
        output data_rgb888,
        output valid,
        output wr_ready,
        input  ready,
        input  we,
        input  addr,
        input  data
    );

    modport slave (
        input  data_rgb888,
        input  valid,
        input  wr_ready,
        output ready,
        output we,
        output addr,
        output data
    );
endinterface

// File: rtl/pixel_format_frame_writer.sv
// RGB888 pixel packer: converts each pixel to the frame's latched format and emits a
// frame-bounded write stream with base-offset addressing and a one-cycle frame-done pulse.
module pixel_format_frame_writer #(
    parameter int unsigned IMG_W      = 480,
    parameter int unsigned IMG_H      = 272,
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  i_Clk_en,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [1:0]            i_mode,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    pixel_format_frame_writer_if.slave px_if,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic [15:0]           o_col,
    output logic [15:0]           o_row
);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    state_e                state_q;
    logic [1:0]            mode_q;
    logic [15:0]           col_q;
    logic [15:0]           row_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  done_q;

    logic ready;
    logic accept;
    logic wr;
    logic last_col;
    logic last_pix;

    // Output register may refill in the same cycle it drains, so streaming has no bubble.
    assign ready    = (state_q == StRun) & i_Clk_en & (~we_q | px_if.wr_ready);
    assign accept   = px_if.valid & ready;
    assign wr       = we_q & px_if.wr_ready & i_Clk_en;
    assign last_col = (col_q == 16'(IMG_W - 1));
    assign last_pix = last_col & (row_q == 16'(IMG_H - 1));

    logic [7:0]  px_r;
    logic [7:0]  px_g;
    logic [7:0]  px_b;
    logic [8:0]  r_rnd;
    logic [8:0]  g_rnd;
    logic [8:0]  b_rnd;
    logic [4:0]  r5_rnd;
    logic [5:0]  g6_rnd;
    logic [4:0]  b5_rnd;
    logic [15:0] y_acc;
    logic [15:0] conv;

    assign px_r = px_if.data_rgb888[23:16];
    assign px_g = px_if.data_rgb888[15:8];
    assign px_b = px_if.data_rgb888[7:0];

    always_comb begin
        r_rnd  = {1'b0, px_r} + 9'd4;
        g_rnd  = {1'b0, px_g} + 9'd2;
        b_rnd  = {1'b0, px_b} + 9'd4;
        // A carry into bit 8 is the only way the rounded value overflows its field.
        r5_rnd = r_rnd[8] ? 5'd31 : r_rnd[7:3];
        g6_rnd = g_rnd[8] ? 6'd63 : g_rnd[7:2];
        b5_rnd = b_rnd[8] ? 5'd31 : b_rnd[7:3];
        y_acc  = 16'd77 * {8'd0, px_r} + 16'd150 * {8'd0, px_g} + 16'd29 * {8'd0, px_b};
        conv   = '0;
        unique case (mode_q)
            2'd0: conv = {px_r[7:3], px_g[7:2], px_b[7:3]};
            2'd1: conv = {r5_rnd, g6_rnd, b5_rnd};
            2'd2: conv = {1'b0, px_r[7:3], px_g[7:3], px_b[7:3]};
            2'd3: conv = {8'h00, y_acc[15:8]};
            default: conv = '0;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= StIdle;
            mode_q  <= 2'd0;
            col_q   <= '0;
            row_q   <= '0;
            waddr_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else if (i_Clk_en) begin
            if (i_abort) begin
                state_q <= StIdle;
                col_q   <= '0;
                row_q   <= '0;
                waddr_q <= '0;
                we_q    <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                if (accept) begin
                    we_q    <= 1'b1;
                    addr_q  <= waddr_q;
                    data_q  <= DATA_WIDTH'(conv);
                    waddr_q <= waddr_q + ADDR_WIDTH'(1);
                    if (last_col) begin
                        col_q <= '0;
                        row_q <= last_pix ? 16'd0 : row_q + 16'd1;
                    end else begin
                        col_q <= col_q + 16'd1;
                    end
                end else if (wr) begin
                    we_q <= 1'b0;
                end

                done_q <= 1'b0;
                unique case (state_q)
                    StIdle: begin
                        if (i_start) begin
                            state_q <= StRun;
                            mode_q  <= i_mode;
                            waddr_q <= i_base_addr;
                            col_q   <= '0;
                            row_q   <= '0;
                        end
                    end
                    StRun: begin
                        if (accept && last_pix) begin
                            state_q <= StFlush;
                        end
                    end
                    StFlush: begin
                        if (wr) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign px_if.ready = ready;
    assign px_if.we    = we_q;
    assign px_if.addr  = addr_q;
    assign px_if.data  = data_q;
    assign o_busy       = (state_q != StIdle);
    assign o_frame_done = done_q;
    assign o_col        = col_q;
    assign o_row        = row_q;

endmodule
